// File: rtl/jedro_1_mem_arbiter_if.sv
// Bundle of the two jedro_1 memory requester ports plus the single-port RAM side.
// slave is the arbiter's view; master is the core/RAM environment's view.
interface jedro_1_mem_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int RAM_AW     = 10
);
  logic                  if_req_i;
  logic [ADDR_WIDTH-1:0] if_addr_i;
  logic                  if_gnt_o;
  logic                  if_rvalid_o;
  logic [DATA_WIDTH-1:0] if_rdata_o;
  logic                  if_err_o;

  logic                  d_req_i;
  logic                  d_we_i;
  logic [3:0]            d_be_i;
  logic [ADDR_WIDTH-1:0] d_addr_i;
  logic [DATA_WIDTH-1:0] d_wdata_i;
  logic                  d_gnt_o;
  logic                  d_rvalid_o;
  logic [DATA_WIDTH-1:0] d_rdata_o;
  logic                  d_err_o;

  logic                  ram_en_o;
  logic [3:0]            ram_we_o;
  logic [RAM_AW-1:0]     ram_addr_o;
  logic [DATA_WIDTH-1:0] ram_wdata_o;
  logic [DATA_WIDTH-1:0] ram_rdata_i;

  modport slave (
    input  if_req_i, if_addr_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
    input  d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
    output d_gnt_o, d_rvalid_o, d_rdata_o, d_err_o,
    output ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o,
    input  ram_rdata_i
  );

  modport master (
    output if_req_i, if_addr_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
    output d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
    input  d_gnt_o, d_rvalid_o, d_rdata_o, d_err_o,
    input  ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o,
    output ram_rdata_i
  );
endinterface

// File: rtl/jedro_1_mem_arbiter.sv
// Shares one single-port, 1-cycle-latency RAM between jedro_1 fetch and data ports.
// Data has priority; a saturating starvation counter forces a fetch grant at STARVE_LIMIT.
module jedro_1_mem_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int RAM_AW       = 10,
  parameter int STARVE_LIMIT = 4
) (
  input logic                 clk_i,
  input logic                 rst_i,
  jedro_1_mem_arbiter_if.slave bus
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [ADDR_WIDTH:0] RANGE_END = (ADDR_WIDTH + 1)'(1) << (RAM_AW + 2);

  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_t;

  logic [CW-1:0] starve_cnt_reg;
  owner_t        owner_reg;
  logic          is_write_reg;
  logic          err_reg;

  logic if_in_range, d_in_range, fetch_starved;
  logic if_gnt, d_gnt, if_ram, d_ram, resp_has_data;

  // addr < 4*2^RAM_AW is the same test as addr[AW-1:2] < 2^RAM_AW
  assign if_in_range   = ({1'b0, bus.if_addr_i} < RANGE_END);
  assign d_in_range    = ({1'b0, bus.d_addr_i} < RANGE_END);
  assign fetch_starved = (starve_cnt_reg == CW'(STARVE_LIMIT));

  assign if_gnt = !rst_i && bus.if_req_i && (!bus.d_req_i || fetch_starved);
  assign d_gnt  = !rst_i && bus.d_req_i && !if_gnt;
  assign if_ram = if_gnt && if_in_range;
  assign d_ram  = d_gnt && d_in_range;

  assign bus.if_gnt_o    = if_gnt;
  assign bus.d_gnt_o     = d_gnt;
  assign bus.ram_en_o    = if_ram || d_ram;
  assign bus.ram_we_o    = (d_ram && bus.d_we_i) ? bus.d_be_i : 4'b0000;
  assign bus.ram_addr_o  = if_ram ? bus.if_addr_i[RAM_AW+1:2] :
                           d_ram  ? bus.d_addr_i[RAM_AW+1:2]  : '0;
  assign bus.ram_wdata_o = (d_ram && bus.d_we_i) ? bus.d_wdata_i : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_cnt_reg <= '0;
      owner_reg      <= OWN_NONE;
      is_write_reg   <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      if (bus.if_req_i && !if_gnt) begin
        if (!fetch_starved) starve_cnt_reg <= starve_cnt_reg + CW'(1);
      end else begin
        starve_cnt_reg <= '0;
      end

      if (if_gnt) begin
        owner_reg    <= OWN_IF;
        is_write_reg <= 1'b0;
        err_reg      <= !if_in_range;
      end else if (d_gnt) begin
        owner_reg    <= OWN_D;
        is_write_reg <= bus.d_we_i;
        err_reg      <= !d_in_range;
      end else begin
        owner_reg    <= OWN_NONE;
        is_write_reg <= 1'b0;
        err_reg      <= 1'b0;
      end
    end
  end

  // Only in-range reads forward RAM data; writes and errors return zero.
  assign resp_has_data   = !is_write_reg && !err_reg;

  assign bus.if_rvalid_o = (owner_reg == OWN_IF);
  assign bus.if_err_o    = (owner_reg == OWN_IF) && err_reg;
  assign bus.if_rdata_o  = ((owner_reg == OWN_IF) && resp_has_data) ? bus.ram_rdata_i : '0;

  assign bus.d_rvalid_o  = (owner_reg == OWN_D);
  assign bus.d_err_o     = (owner_reg == OWN_D) && err_reg;
  assign bus.d_rdata_o   = ((owner_reg == OWN_D) && resp_has_data) ? bus.ram_rdata_i : '0;
endmodule

// File: tb/tb_jedro_1_mem_arbiter.sv
// Randomised and directed bench for jedro_1_mem_arbiter against a transaction-level model
// (arbitration rule, one-deep response slot and a reference word memory).
module tb_jedro_1_mem_arbiter;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int RAW = 10;
  localparam int LIMIT = 4;
  localparam int WORDS = 1 << RAW;
  localparam longint unsigned RANGE_BYTES = 4 * WORDS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  jedro_1_mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_AW(RAW)) bus ();

  jedro_1_mem_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_AW(RAW), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  // Physical RAM attached to the DUT: synchronous, byte-writable, registered read.
  logic [31:0] ram_mem [0:WORDS-1];
  always @(posedge clk) begin
    if (bus.ram_en_o) begin
      for (int b = 0; b < 4; b++)
        if (bus.ram_we_o[b]) ram_mem[bus.ram_addr_o][8*b +: 8] <= bus.ram_wdata_o[8*b +: 8];
      bus.ram_rdata_i <= ram_mem[bus.ram_addr_o];
    end
  end

  // Reference model state
  logic [31:0] ref_mem [0:WORDS-1];
  int          m_starve;
  int          m_owner;      // 0 none, 1 fetch, 2 data
  bit          m_err;
  logic [31:0] m_data;

  int checks = 0;
  int errors = 0;

  // Values sampled / predicted in the most recent cycle
  bit          last_if_gnt, last_d_gnt, last_ram_en, last_if_rvalid, last_d_rvalid, last_d_err;
  bit          last_eg_if, last_eg_d;
  logic [3:0]  last_ram_we;
  logic [31:0] last_if_rdata, last_d_rdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic bit in_range(input logic [31:0] a);
    return longint'(a) < RANGE_BYTES;
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a / 4) % WORDS);
  endfunction

  task automatic set_idle();
    bus.if_req_i  = 1'b0; bus.if_addr_i = '0;
    bus.d_req_i   = 1'b0; bus.d_we_i = 1'b0; bus.d_be_i = 4'b0;
    bus.d_addr_i  = '0;   bus.d_wdata_i = '0;
  endtask

  task automatic fetch(input logic [31:0] a);
    set_idle(); bus.if_req_i = 1'b1; bus.if_addr_i = a;
  endtask

  task automatic dread(input logic [31:0] a);
    set_idle(); bus.d_req_i = 1'b1; bus.d_addr_i = a;
  endtask

  task automatic dwrite(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
    set_idle(); bus.d_req_i = 1'b1; bus.d_we_i = 1'b1; bus.d_addr_i = a;
    bus.d_be_i = be; bus.d_wdata_i = wd;
  endtask

  // One clock cycle: predict, compare at negedge, then advance the model at posedge.
  task automatic step();
    bit e_if, e_d, if_ok, d_ok, e_en, e_ifv, e_dv, e_ife, e_de;
    logic [3:0]  e_we;
    logic [31:0] e_ifd, e_dd;
    int          e_word;
    @(negedge clk);
    if_ok = in_range(bus.if_addr_i);
    d_ok  = in_range(bus.d_addr_i);
    e_if  = !rst && bus.if_req_i && (!bus.d_req_i || m_starve == LIMIT);
    e_d   = !rst && bus.d_req_i && !e_if;
    e_en  = (e_if && if_ok) || (e_d && d_ok);
    e_we  = (e_d && d_ok && bus.d_we_i) ? bus.d_be_i : 4'b0;
    e_word = e_if ? word_of(bus.if_addr_i) : word_of(bus.d_addr_i);
    e_ifv = !rst && m_owner == 1;
    e_dv  = !rst && m_owner == 2;
    e_ife = e_ifv && m_err;
    e_de  = e_dv && m_err;
    e_ifd = e_ifv ? m_data : 32'h0;
    e_dd  = e_dv ? m_data : 32'h0;

    chk("if_gnt", {31'b0, bus.if_gnt_o}, {31'b0, e_if});
    chk("d_gnt", {31'b0, bus.d_gnt_o}, {31'b0, e_d});
    chk("ram_en", {31'b0, bus.ram_en_o}, {31'b0, e_en});
    chk("ram_we", {28'b0, bus.ram_we_o}, {28'b0, e_we});
    if (e_en) chk("ram_addr", 32'(bus.ram_addr_o), 32'(e_word));
    if (e_we != 4'b0) chk("ram_wdata", bus.ram_wdata_o, bus.d_wdata_i);
    if (!e_if && !e_d) begin
      chk("idle_addr", 32'(bus.ram_addr_o), 32'h0);
      chk("idle_wdata", bus.ram_wdata_o, 32'h0);
    end
    chk("if_rvalid", {31'b0, bus.if_rvalid_o}, {31'b0, e_ifv});
    chk("if_err", {31'b0, bus.if_err_o}, {31'b0, e_ife});
    chk("if_rdata", bus.if_rdata_o, e_ifd);
    chk("d_rvalid", {31'b0, bus.d_rvalid_o}, {31'b0, e_dv});
    chk("d_err", {31'b0, bus.d_err_o}, {31'b0, e_de});
    chk("d_rdata", bus.d_rdata_o, e_dd);

    if (bus.if_rvalid_o) $display("resp if data=%h err=%0b t=%0t", bus.if_rdata_o, bus.if_err_o, $time);
    if (bus.d_rvalid_o)  $display("resp d  data=%h err=%0b t=%0t", bus.d_rdata_o, bus.d_err_o, $time);

    last_if_gnt = bus.if_gnt_o;   last_d_gnt = bus.d_gnt_o;   last_ram_en = bus.ram_en_o;
    last_ram_we = bus.ram_we_o;   last_if_rvalid = bus.if_rvalid_o;
    last_d_rvalid = bus.d_rvalid_o; last_d_err = bus.d_err_o;
    last_if_rdata = bus.if_rdata_o; last_d_rdata = bus.d_rdata_o;
    last_eg_if = e_if; last_eg_d = e_d;

    @(posedge clk);
    if (rst) begin
      m_starve = 0; m_owner = 0; m_err = 0; m_data = 0;
    end else begin
      m_starve = (bus.if_req_i && !e_if) ? ((m_starve < LIMIT) ? m_starve + 1 : LIMIT) : 0;
      if (e_if) begin
        m_owner = 1; m_err = !if_ok;
        m_data  = if_ok ? ref_mem[word_of(bus.if_addr_i)] : 32'h0;
      end else if (e_d) begin
        m_owner = 2; m_err = !d_ok;
        m_data  = (d_ok && !bus.d_we_i) ? ref_mem[word_of(bus.d_addr_i)] : 32'h0;
        if (d_ok && bus.d_we_i)
          for (int b = 0; b < 4; b++)
            if (bus.d_be_i[b]) ref_mem[word_of(bus.d_addr_i)][8*b +: 8] = bus.d_wdata_i[8*b +: 8];
      end else begin
        m_owner = 0; m_err = 0; m_data = 0;
      end
    end
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 9) == 0)
      return ($urandom_range(0, 1) == 0) ? (32'(RANGE_BYTES) + 32'($urandom_range(0, 63))) : $urandom;
    return 32'($urandom_range(0, 31) * 4 + $urandom_range(0, 3));
  endfunction

  initial begin
    logic [9:0] pattern;
    bit if_pend, d_pend;

    for (int i = 0; i < WORDS; i++) begin
      ram_mem[i] = 32'hA5A50000 + 32'(i);
      ref_mem[i] = 32'hA5A50000 + 32'(i);
    end
    ram_mem[4] = 32'h11223344;
    ref_mem[4] = 32'h11223344;
    bus.ram_rdata_i = '0;
    m_starve = 0; m_owner = 0; m_err = 0; m_data = 0;

    // Reset held with both ports requesting
    set_idle();
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h4;
    bus.d_req_i  = 1'b1; bus.d_addr_i  = 32'h8;
    #2;
    step();
    chk("rst_if_gnt", {31'b0, last_if_gnt}, 32'h0);
    chk("rst_d_gnt", {31'b0, last_d_gnt}, 32'h0);
    chk("rst_ram_en", {31'b0, last_ram_en}, 32'h0);
    step();
    rst = 1'b0;

    // First cycle out of reset: fetch of word 1
    fetch(32'h0000_0004);
    step();
    chk("first_if_gnt", {31'b0, last_if_gnt}, 32'h1);
    set_idle();
    step();
    chk("first_if_rvalid", {31'b0, last_if_rvalid}, 32'h1);
    chk("first_if_rdata", last_if_rdata, 32'hA5A50001);

    // Partial write then read back
    dwrite(32'h10, 4'b0101, 32'hDEADBEEF);
    step();
    chk("wr_ram_we", {28'b0, last_ram_we}, 32'h5);
    set_idle();
    step();
    chk("wr_ack", {31'b0, last_d_rvalid}, 32'h1);
    chk("wr_ack_rdata", last_d_rdata, 32'h0);
    dread(32'h10);
    step();
    set_idle();
    step();
    chk("rd_merged", last_d_rdata, 32'h11AD33EF);

    // Continuous contention: d,d,d,d,if repeating
    set_idle();
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h8;
    bus.d_req_i  = 1'b1; bus.d_addr_i  = 32'hC;
    for (int k = 0; k < 10; k++) begin
      step();
      pattern[9-k] = last_if_gnt;
    end
    chk("starve_pattern", 32'(pattern), 32'(10'b0000100001));
    set_idle();
    step();

    // Out-of-range read and write
    dread(32'(RANGE_BYTES));
    step();
    chk("oor_ram_en", {31'b0, last_ram_en}, 32'h0);
    set_idle();
    step();
    chk("oor_err", {31'b0, last_d_err}, 32'h1);
    chk("oor_rdata", last_d_rdata, 32'h0);
    dwrite(32'(RANGE_BYTES), 4'hF, 32'hFFFF_FFFF);
    step();
    set_idle();
    step();
    dread(32'h0);
    step();
    set_idle();
    step();
    chk("oor_no_alias", last_d_rdata, 32'hA5A50000);

    // Alternating single-cycle fetch / data reads
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) fetch(32'(k * 4));
      else            dread(32'(k * 4 + 64));
      step();
    end
    set_idle();
    step();

    // Reset between a data read grant and its response
    dread(32'h14);
    step();
    set_idle();
    #2 rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    chk("rst_midop_rvalid", {31'b0, last_d_rvalid}, 32'h0);
    step();

    // Randomised traffic; requesters hold until the model says they were granted
    if_pend = 0; d_pend = 0;
    set_idle();
    for (int c = 0; c < 1500; c++) begin
      if (!if_pend && $urandom_range(0, 3) != 0) begin
        if_pend = 1; bus.if_req_i = 1'b1; bus.if_addr_i = rand_addr();
      end
      if (!d_pend && $urandom_range(0, 3) != 0) begin
        d_pend = 1; bus.d_req_i = 1'b1; bus.d_addr_i = rand_addr();
        bus.d_we_i = ($urandom_range(0, 2) == 0);
        bus.d_be_i = 4'($urandom); bus.d_wdata_i = $urandom;
      end
      step();
      if (last_eg_if) begin if_pend = 0; bus.if_req_i = 1'b0; bus.if_addr_i = '0; end
      if (last_eg_d) begin
        d_pend = 0; bus.d_req_i = 1'b0; bus.d_we_i = 1'b0;
        bus.d_be_i = '0; bus.d_addr_i = '0; bus.d_wdata_i = '0;
      end
    end
    set_idle();
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/jedro_1_mem_arbiter.md
# jedro_1_mem_arbiter

Single-port memory arbiter that lets the jedro_1 core share one byte-writable RAM between its instruction-fetch port and its data load/store port. Sits between the core's two memory masters and a single-port, 1-cycle-read-latency RAM. Grants one access per cycle and routes each response back to its owner. Data accesses have priority, with a starvation counter that guarantees forward progress for fetch.

## Interface
Parameters:
- DATA_WIDTH, 32, width of every data bus; must be 32.
- ADDR_WIDTH, 32, byte address width on both requester ports.
- RAM_AW, 10, RAM word-address width; mapped range is bytes 0 .. 4*2^RAM_AW-1.
- STARVE_LIMIT, 4, consecutive denied fetch cycles before fetch wins arbitration; must be ≥1.

Ports:
- clk_i, in, 1, clock; all state updates on rising edge.
- rst_i, in, 1, reset; asynchronous, active-high.
- if_req_i, in, 1, fetch request.
- if_addr_i, in, ADDR_WIDTH, fetch byte address; bits [1:0] ignored.
- if_gnt_o, out, 1, fetch granted this cycle.
- if_rvalid_o, out, 1, fetch response valid.
- if_rdata_o, out, DATA_WIDTH, fetch read data.
- if_err_o, out, 1, fetch response is an out-of-range error.
- d_req_i, in, 1, data request.
- d_we_i, in, 1, 1 = write, 0 = read.
- d_be_i, in, 4, byte enables for writes.
- d_addr_i, in, ADDR_WIDTH, data byte address; bits [1:0] ignored.
- d_wdata_i, in, DATA_WIDTH, write data.
- d_gnt_o, out, 1, data granted this cycle.
- d_rvalid_o, out, 1, data response valid.
- d_rdata_o, out, DATA_WIDTH, data read data.
- d_err_o, out, 1, data response is an out-of-range error.
- ram_en_o, out, 1, RAM access enable.
- ram_we_o, out, 4, RAM byte write enables.
- ram_addr_o, out, RAM_AW, RAM word address.
- ram_wdata_o, out, DATA_WIDTH, RAM write data.
- ram_rdata_i, in, DATA_WIDTH, RAM read data, valid the cycle after ram_en_o.

## Operation
- Arbitration is combinational on the current cycle's requests. At most one grant per cycle.
  - Only one requester: it wins.
  - Both requesting: data wins, unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
- starve_cnt (registered, saturating at STARVE_LIMIT):
  - +1 when if_req_i is high and if_gnt_o is low.
  - Cleared to 0 when fetch is granted or if_req_i is low.
- Range check: the access is in range when addr[ADDR_WIDTH-1:2] < 2^RAM_AW.
- Granted in-range access:
  - ram_en_o=1 and ram_addr_o=addr[RAM_AW+1:2].
  - Data write: ram_we_o=d_be_i and ram_wdata_o=d_wdata_i.
  - Otherwise ram_we_o=0.
- Granted out-of-range access: ram_en_o=0 and no RAM side effect.
- Fetch port is read-only; there are no write inputs on it.
- Response register captures owner (none/if/d), is_write and err at every grant edge.
- Response cycle (exactly one cycle after the grant): the owner's rvalid=1; the other port's rvalid=0.
  - rdata = ram_rdata_i for an in-range read, else 0.
  - err = 1 only for out-of-range.
- Writes also receive an rvalid acknowledge: rdata=0, err=0. A write with d_be_i=0 is a granted no-op that still acks.
- Idle cycles: ram_en_o=0, ram_we_o=0. ram_addr_o and ram_wdata_o are don't-care but driven 0.

## Timing
- Grant: same cycle as the request, combinational. Requesters hold request and payload until granted.
- Response latency is fixed at 1 cycle after the grant, for reads, writes and errors alike.
- Back-to-back grants are allowed every cycle, to either port. Responses pipeline without bubbles.
- A new grant and the previous grant's response may occur in the same cycle, on the same or different ports.
- Reset (asynchronous assert):
  - if_gnt_o, d_gnt_o, ram_en_o, ram_we_o: 0 while rst_i is high, regardless of requests.
  - if_rvalid_o, d_rvalid_o, if_err_o, d_err_o: 0.
  - Both rdata outputs: 0.
  - starve_cnt: 0. Response owner: none.
- Reset mid-operation: any pending response is dropped and no rvalid appears after reset release. A RAM write already enabled in the clock edge before reset is not undone.
- First grant is possible in the first cycle with rst_i low.

## Test plan
- Reset: hold rst_i=1 with both ports requesting → all outputs 0. Deassert → fetch-only req at 0x0000_0004 grants the same cycle; next cycle if_rvalid_o=1 with RAM word 1.
- Write/read: data write 0xDEADBEEF, be=4'b0101 to 0x10 over a word of 0x11223344 → d_rvalid_o ack, rdata=0. Read 0x10 → 0x11AD33EF.
- Contention: both ports request continuously with STARVE_LIMIT=4 → grant pattern d,d,d,d,if repeats. Fetch is granted on the 5th cycle and starve_cnt returns to 0.
- Out of range: data read at 4*2^RAM_AW → ram_en_o=0; next cycle d_rvalid_o=1, d_err_o=1, d_rdata_o=0. A write there leaves the RAM unchanged.
- Back-to-back: alternating single-cycle if/d reads at consecutive cycles → each response lands on the correct port exactly 1 cycle after its grant, with no bubbles.
- Reset mid-op: assert rst_i asynchronously between a data read grant and its response → no d_rvalid_o pulse after release.
